shifter_barrel_pipe: RTL and testbench
======================================

# shifter_barrel_pipe

Pipelined, parametrised barrel shifter with a valid/ready handshake. It supports logical, arithmetic and rotate shifts in both directions, saturating semantics for out-of-range non-rotate amounts, a carry-out flag and a pass-through sideband tag. It sits in the common datapath library for ALU and bit-manipulation paths that need a registered, back-pressurable shifter at high clock rates.

## Interface
Parameters:
- WIDTH, 32, data width; must be a power of two, ≥ 4.
- PIPE_STAGES, 2, number of register stages, 1..$clog2(WIDTH); latency equals this value.
- TAG_W, 4, sideband tag width, ≥ 1.

Ports (clock/reset per decision: one clock; reset is synchronous and active-high):
- i_clk  input  1  clock
- i_rst  input  1  synchronous active-high reset
- i_valid  input  1  request valid
- o_ready  output  1  request accepted when i_valid && o_ready
- i_data  input  WIDTH  operand
- i_ctrl  input  3  op: 000 none, 001 LSR, 010 ASR, 011 ROR, 100 LSL, 110 ROL; 101/111 reserved
- i_shift_amount  input  $clog2(WIDTH)+1  shift amount, 0..2*WIDTH-1
- i_tag  input  TAG_W  sideband, returned unchanged
- o_valid  output  1  result valid
- i_ready  input  1  downstream ready
- o_data  output  WIDTH  result
- o_carry  output  1  last bit shifted out
- o_tag  output  TAG_W  tag of this result

## Operation
- Datapath: LOG2W=$clog2(WIDTH) mux levels. Level j shifts by 2^j when amount bit j is set. Level j resides in register stage floor(j*PIPE_STAGES/LOG2W). Each stage registers data, op, remaining amount, tag, carry and valid.
- LSR/LSL: amt ≥ WIDTH gives 0 (saturating, not modulo). LSR fill is 0.
- ASR: amt ≥ WIDTH gives all bits = i_data[WIDTH-1].
- ROR/ROL: effective amount = amt mod WIDTH.
- none, and reserved ops: o_data = i_data, o_carry = 0.
- amt = 0 for any op: o_data = i_data, o_carry = 0.
- Carry:
  - LSR/ASR, 1 ≤ amt ≤ WIDTH: i_data[amt-1].
  - LSL, 1 ≤ amt ≤ WIDTH: i_data[WIDTH-amt].
  - LSL/LSR, amt > WIDTH: 0.
  - ASR, amt > WIDTH: sign bit.
  - ROR: o_data[WIDTH-1]. ROL: o_data[0]. Both are 0 when the effective amount is 0.
- Handshake, per stage k:
  - Stage k loads when it is empty or stage k+1 loads. The last stage loads when it is empty or i_ready is high.
  - o_ready = load-enable of stage 0. It is combinational from i_ready through the stage valids; no registered skid.
  - o_valid = last-stage valid. While o_valid && !i_ready, o_data, o_carry and o_tag hold stable.
- Bubbles collapse: a downstream stall does not block upstream stages that are empty.
- Ordering is strictly FIFO and no transfer is dropped or duplicated.

## Timing
- Latency: a request accepted in cycle N appears on o_valid in cycle N+PIPE_STAGES, provided there is no stall.
- Throughput: one result per cycle with i_ready held high.
- Reset: all stage valids = 0 and all data/carry/tag registers = 0. So o_valid=0, o_data=0, o_carry=0, o_tag=0. o_ready=1 in the first cycle after reset deasserts.
- Reset asserted mid-flight discards all in-flight transfers; nothing is emitted afterward.
- Simultaneous input accept and output drain in a full pipeline: both occur in the same cycle and occupancy is unchanged.

## Configuration
- SHIFTER_BARREL_PIPE_CARRY_EN:
  - Defined: carry logic and carry pipeline registers are built, and o_carry behaves as specified.
  - Undefined: carry logic and registers are omitted, and o_carry is tied to 0.
- The port list is identical in both builds.

## Structure
- Shared package shifter_pkg holds:
  - enum shift_op_e (encodings above).
  - function shift_is_rotate().
  - Localparams SHIFT_OP_W=3 and the reserved-code list.
- One sub-module, shifter_pipe_stage, is instantiated PIPE_STAGES times. It contains:
  - A parameterised range of mux levels (first/last level).
  - The valid/load logic and the stage registers.

## Test plan
- WIDTH=8, PIPE_STAGES=2, LSR 8'hB4 amt 3 → o_data 8'h16, o_carry 1, o_valid exactly 2 cycles after accept.
- ASR 8'h80 amt 12 → 8'hFF, carry 1. LSL 8'h01 amt 8 → 8'h00, carry 1. LSL 8'h01 amt 9 → 8'h00, carry 0.
- ROR 8'h81 amt 9 → 8'hC0, carry 1. ROL 8'h81 amt 1 → 8'h03, carry 1. Reserved op 3'b101 with 8'h5A → 8'h5A, carry 0.
- Stream of 6 requests with tags 0..5, i_ready low for 5 cycles starting after the first result:
  - o_ready drops once the pipeline is full.
  - Outputs stay stable during the stall.
  - All 6 results arrive in tag order with none lost.
- i_rst pulsed for 1 cycle with 2 requests in flight → o_valid=0 and o_data=0 next cycle; no stale result ever appears.
- Build without SHIFTER_BARREL_PIPE_CARRY_EN and rerun the first scenario → identical o_data and latency, o_carry constantly 0.

Source files
------------

// File: rtl/shifter_pkg.sv
// Shared op encodings and helpers for the pipelined barrel shifter.
// Carry support is selected by SHIFTER_BARREL_PIPE_CARRY_EN in the users of this package.
package shifter_pkg;

  localparam int SHIFT_OP_W = 3;

  typedef enum logic [SHIFT_OP_W-1:0] {
    OP_NONE = 3'b000,
    OP_LSR  = 3'b001,
    OP_ASR  = 3'b010,
    OP_ROR  = 3'b011,
    OP_LSL  = 3'b100,
    OP_ROL  = 3'b110
  } shift_op_e;

  // Reserved codes behave as OP_NONE.
  localparam logic [SHIFT_OP_W-1:0] SHIFT_OP_RSVD0 = 3'b101;
  localparam logic [SHIFT_OP_W-1:0] SHIFT_OP_RSVD1 = 3'b111;

  function automatic logic shift_is_rotate(input logic [SHIFT_OP_W-1:0] op);
    return (op == OP_ROR) || (op == OP_ROL);
  endfunction

endpackage

// File: rtl/shifter_pipe_stage.sv
// One register stage of the barrel shifter: its share of mux levels plus valid/load logic.
// Carry path and carry register exist only when SHIFTER_BARREL_PIPE_CARRY_EN is defined.
module shifter_pipe_stage
  import shifter_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int TAG_W       = 4,
  parameter int PIPE_STAGES = 2,
  parameter int STAGE       = 0,
  parameter int LOG2W       = $clog2(WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  next_load,
  output logic                  load,
  input  logic                  up_valid,
  input  logic [WIDTH-1:0]      up_data,
  input  logic [SHIFT_OP_W-1:0] up_op,
  input  logic [LOG2W-1:0]      up_amt,
  input  logic [TAG_W-1:0]      up_tag,
`ifdef SHIFTER_BARREL_PIPE_CARRY_EN
  input  logic                  up_carry,
  output logic                  dn_carry,
`endif
  output logic                  dn_valid,
  output logic [WIDTH-1:0]      dn_data,
  output logic [SHIFT_OP_W-1:0] dn_op,
  output logic [LOG2W-1:0]      dn_amt,
  output logic [TAG_W-1:0]      dn_tag
);

  logic                  valid_r;
  logic [WIDTH-1:0]      data_r;
  logic [SHIFT_OP_W-1:0] op_r;
  logic [LOG2W-1:0]      amt_r;
  logic [TAG_W-1:0]      tag_r;
  logic [WIDTH-1:0]      data_s;
  logic [LOG2W-1:0]      lo_idx_s;
  logic [LOG2W-1:0]      hi_idx_s;
  int                    sh_s;
`ifdef SHIFTER_BARREL_PIPE_CARRY_EN
  logic                  carry_r;
  logic                  carry_s;
`endif

  // Bubble collapse: an empty stage always accepts.
  assign load = !valid_r || next_load;

  // Mux levels owned by this stage; each later level overrides the carry of earlier ones.
  always_comb begin
    data_s   = up_data;
    sh_s     = 0;
    lo_idx_s = {LOG2W{1'b0}};
    hi_idx_s = {LOG2W{1'b0}};
`ifdef SHIFTER_BARREL_PIPE_CARRY_EN
    carry_s  = up_carry;
`endif
    for (int j = 0; j < LOG2W; j++) begin
      if ((((j * PIPE_STAGES) / LOG2W) == STAGE) && up_amt[j]) begin
        sh_s     = 1 << j;
        lo_idx_s = LOG2W'(sh_s - 1);
        hi_idx_s = LOG2W'(WIDTH - sh_s);
        case (up_op)
          OP_LSR: begin
`ifdef SHIFTER_BARREL_PIPE_CARRY_EN
            carry_s = data_s[lo_idx_s];
`endif
            data_s = data_s >> sh_s;
          end
          OP_ASR: begin
`ifdef SHIFTER_BARREL_PIPE_CARRY_EN
            carry_s = data_s[lo_idx_s];
`endif
            data_s = $signed(data_s) >>> sh_s;
          end
          OP_ROR: begin
            data_s = (data_s >> sh_s) | (data_s << (WIDTH - sh_s));
`ifdef SHIFTER_BARREL_PIPE_CARRY_EN
            carry_s = data_s[WIDTH-1];
`endif
          end
          OP_LSL: begin
`ifdef SHIFTER_BARREL_PIPE_CARRY_EN
            carry_s = data_s[hi_idx_s];
`endif
            data_s = data_s << sh_s;
          end
          OP_ROL: begin
            data_s = (data_s << sh_s) | (data_s >> (WIDTH - sh_s));
`ifdef SHIFTER_BARREL_PIPE_CARRY_EN
            carry_s = data_s[0];
`endif
          end
          default: begin
            data_s = data_s;
          end
        endcase
      end else begin
        data_s = data_s;
      end
    end
  end

  // Stage registers: hold while stalled, payload only captured for valid requests.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_r <= 1'b0;
      data_r  <= {WIDTH{1'b0}};
      op_r    <= {SHIFT_OP_W{1'b0}};
      amt_r   <= {LOG2W{1'b0}};
      tag_r   <= {TAG_W{1'b0}};
`ifdef SHIFTER_BARREL_PIPE_CARRY_EN
      carry_r <= 1'b0;
`endif
    end else if (load) begin
      valid_r <= up_valid;
      if (up_valid) begin
        data_r  <= data_s;
        op_r    <= up_op;
        amt_r   <= up_amt;
        tag_r   <= up_tag;
`ifdef SHIFTER_BARREL_PIPE_CARRY_EN
        carry_r <= carry_s;
`endif
      end
    end
  end

  assign dn_valid = valid_r;
  assign dn_data  = data_r;
  assign dn_op    = op_r;
  assign dn_amt   = amt_r;
  assign dn_tag   = tag_r;
`ifdef SHIFTER_BARREL_PIPE_CARRY_EN
  assign dn_carry = carry_r;
`endif

endmodule

// File: rtl/shifter_barrel_pipe.sv
// Pipelined barrel shifter with valid/ready handshake and sideband tag.
// Define SHIFTER_BARREL_PIPE_CARRY_EN to build the carry-out path; otherwise o_carry is 0.
module shifter_barrel_pipe
  import shifter_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int PIPE_STAGES = 2,
  parameter int TAG_W       = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_valid,
  output logic                     o_ready,
  input  logic [WIDTH-1:0]         i_data,
  input  logic [2:0]               i_ctrl,
  input  logic [$clog2(WIDTH):0]   i_shift_amount,
  input  logic [TAG_W-1:0]         i_tag,
  output logic                     o_valid,
  input  logic                     i_ready,
  output logic [WIDTH-1:0]         o_data,
  output logic                     o_carry,
  output logic [TAG_W-1:0]         o_tag
);

  localparam int LOG2W = $clog2(WIDTH);
  localparam int AMT_W = LOG2W + 1;

  logic [PIPE_STAGES:0]  valid_s;
  logic [PIPE_STAGES:0]  load_s;
  logic [WIDTH-1:0]      data_s [PIPE_STAGES+1];
  logic [SHIFT_OP_W-1:0] op_s   [PIPE_STAGES+1];
  logic [LOG2W-1:0]      amt_s  [PIPE_STAGES+1];
  logic [TAG_W-1:0]      tag_s  [PIPE_STAGES+1];
  logic [WIDTH-1:0]      data_n_s;
  logic [LOG2W-1:0]      amt_n_s;
`ifdef SHIFTER_BARREL_PIPE_CARRY_EN
  logic [PIPE_STAGES:0]  carry_s;
  logic                  carry_n_s;
`endif

  // Saturating and no-op cases are resolved up front so the mux levels only see in-range amounts.
  always_comb begin
    data_n_s  = i_data;
    amt_n_s   = i_shift_amount[LOG2W-1:0];
`ifdef SHIFTER_BARREL_PIPE_CARRY_EN
    carry_n_s = 1'b0;
`endif
    case (i_ctrl)
      OP_LSR, OP_LSL: begin
        if (i_shift_amount[LOG2W]) begin
          data_n_s = {WIDTH{1'b0}};
          amt_n_s  = {LOG2W{1'b0}};
`ifdef SHIFTER_BARREL_PIPE_CARRY_EN
          if (i_shift_amount == AMT_W'(WIDTH)) begin
            carry_n_s = (i_ctrl == OP_LSR) ? i_data[WIDTH-1] : i_data[0];
          end else begin
            carry_n_s = 1'b0;
          end
`endif
        end else begin
          amt_n_s = i_shift_amount[LOG2W-1:0];
        end
      end
      OP_ASR: begin
        if (i_shift_amount[LOG2W]) begin
          data_n_s  = {WIDTH{i_data[WIDTH-1]}};
          amt_n_s   = {LOG2W{1'b0}};
`ifdef SHIFTER_BARREL_PIPE_CARRY_EN
          carry_n_s = i_data[WIDTH-1];
`endif
        end else begin
          amt_n_s = i_shift_amount[LOG2W-1:0];
        end
      end
      default: begin
        if (shift_is_rotate(i_ctrl)) begin
          amt_n_s = i_shift_amount[LOG2W-1:0];
        end else begin
          amt_n_s = {LOG2W{1'b0}};
        end
      end
    endcase
  end

  assign valid_s[0]           = i_valid;
  assign data_s[0]            = data_n_s;
  assign op_s[0]              = i_ctrl;
  assign amt_s[0]             = amt_n_s;
  assign tag_s[0]             = i_tag;
  assign load_s[PIPE_STAGES]  = i_ready;
`ifdef SHIFTER_BARREL_PIPE_CARRY_EN
  assign carry_s[0]           = carry_n_s;
`endif

  for (genvar k = 0; k < PIPE_STAGES; k++) begin : g_stage
    shifter_pipe_stage #(
      .WIDTH       (WIDTH),
      .TAG_W       (TAG_W),
      .PIPE_STAGES (PIPE_STAGES),
      .STAGE       (k),
      .LOG2W       (LOG2W)
    ) u_stage (
      .clk       (i_clk),
      .rst       (i_rst),
      .next_load (load_s[k+1]),
      .load      (load_s[k]),
      .up_valid  (valid_s[k]),
      .up_data   (data_s[k]),
      .up_op     (op_s[k]),
      .up_amt    (amt_s[k]),
      .up_tag    (tag_s[k]),
`ifdef SHIFTER_BARREL_PIPE_CARRY_EN
      .up_carry  (carry_s[k]),
      .dn_carry  (carry_s[k+1]),
`endif
      .dn_valid  (valid_s[k+1]),
      .dn_data   (data_s[k+1]),
      .dn_op     (op_s[k+1]),
      .dn_amt    (amt_s[k+1]),
      .dn_tag    (tag_s[k+1])
    );
  end

  assign o_ready = load_s[0];
  assign o_valid = valid_s[PIPE_STAGES];
  assign o_data  = data_s[PIPE_STAGES];
  assign o_tag   = tag_s[PIPE_STAGES];
`ifdef SHIFTER_BARREL_PIPE_CARRY_EN
  assign o_carry = carry_s[PIPE_STAGES];
`else
  assign o_carry = 1'b0;
`endif

endmodule

// File: tb/tb_shifter_barrel_pipe.sv
// Scoreboard bench for shifter_barrel_pipe at WIDTH=8, PIPE_STAGES=2.
// Expected carry follows SHIFTER_BARREL_PIPE_CARRY_EN (0 when undefined).
module tb_shifter_barrel_pipe;

  localparam int W  = 8;
  localparam int P  = 2;
  localparam int TW = 4;
  localparam int AW = 4;
`ifdef SHIFTER_BARREL_PIPE_CARRY_EN
  localparam bit CARRY_ON = 1'b1;
`else
  localparam bit CARRY_ON = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          i_rst, i_valid, i_ready;
  logic          o_ready, o_valid, o_carry;
  logic [W-1:0]  i_data, o_data;
  logic [2:0]    i_ctrl;
  logic [AW-1:0] i_shift_amount;
  logic [TW-1:0] i_tag, o_tag;

  always #5 clk = ~clk;

  shifter_barrel_pipe #(.WIDTH(W), .PIPE_STAGES(P), .TAG_W(TW)) dut (
    .i_clk(clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
    .i_data(i_data), .i_ctrl(i_ctrl), .i_shift_amount(i_shift_amount), .i_tag(i_tag),
    .o_valid(o_valid), .i_ready(i_ready), .o_data(o_data), .o_carry(o_carry), .o_tag(o_tag)
  );

  typedef struct packed {
    logic [W-1:0]  data;
    logic          carry;
    logic [TW-1:0] tag;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_out    = 0;
  bit   saw_busy = 1'b0;
  bit   rnd_done = 1'b0;

  task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic [2:0] op, input logic [W-1:0] d,
                                 input logic [AW-1:0] amt, input logic [TW-1:0] tag);
    exp_t e;
    int a, r;
    logic [W-1:0] res;
    logic c;
    a = int'(amt);
    r = a % W;
    res = d;
    c = 1'b0;
    case (op)
      3'b001: begin
        if (a >= W) res = '0; else res = d >> a;
        if (a >= 1 && a <= W) c = d[a-1];
      end
      3'b010: begin
        if (a >= W) res = {W{d[W-1]}}; else res = $signed(d) >>> a;
        if (a >= 1 && a <= W) c = d[a-1];
        else if (a > W) c = d[W-1];
      end
      3'b100: begin
        if (a >= W) res = '0; else res = d << a;
        if (a >= 1 && a <= W) c = d[W-a];
      end
      3'b011: begin
        res = (d >> r) | (d << (W - r));
        if (r != 0) c = res[W-1];
      end
      3'b110: begin
        res = (d << r) | (d >> (W - r));
        if (r != 0) c = res[0];
      end
      default: ;
    endcase
    e.data  = res;
    e.carry = c & CARRY_ON;
    e.tag   = tag;
    return e;
  endfunction

  // Monitor: push on accept, pop/compare on output transfer, check hold during stalls.
  initial begin
    exp_t e;
    bit prev_stall;
    logic [W+TW:0] prev_out;
    prev_stall = 1'b0;
    prev_out = '0;
    forever begin
      @(negedge clk);
      if (!i_rst) begin
        if (prev_stall)
          check_eq("stall_hold", {o_valid, o_data, o_carry, o_tag}, {1'b1, prev_out});
        if (i_valid && o_ready) sb_q.push_back(model(i_ctrl, i_data, i_shift_amount, i_tag));
        if (o_valid && i_ready) begin
          if (sb_q.size() == 0) begin
            check_eq("spurious_valid", o_valid, 1'b0);
          end else begin
            e = sb_q.pop_front();
            check_eq("data", o_data, e.data);
            check_eq("carry", o_carry, e.carry);
            check_eq("tag", o_tag, e.tag);
            n_out++;
          end
        end
        if (!o_ready) saw_busy = 1'b1;
        prev_stall = o_valid && !i_ready;
        prev_out = {o_data, o_carry, o_tag};
      end else begin
        prev_stall = 1'b0;
      end
    end
  end

  // Single request with latency measurement; pipeline must be idle beforehand.
  task automatic directed(input logic [2:0] op, input logic [W-1:0] d, input logic [AW-1:0] amt,
                          input logic [TW-1:0] tag);
    int lat;
    @(posedge clk); #1;
    i_ctrl = op; i_data = d; i_shift_amount = amt; i_tag = tag; i_valid = 1'b1;
    @(negedge clk);
    check_eq("accept_ready", o_ready, 1'b1);
    @(posedge clk); #1;
    i_valid = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!o_valid && lat < 10);
    check_eq("latency", lat, P);
  endtask

  // Present one request and hold it until accepted (bounded).
  task automatic push_req(input logic [2:0] op, input logic [W-1:0] d, input logic [AW-1:0] amt,
                          input logic [TW-1:0] tag);
    int waits;
    bit acc;
    @(posedge clk); #1;
    i_ctrl = op; i_data = d; i_shift_amount = amt; i_tag = tag; i_valid = 1'b1;
    waits = 0;
    acc = 1'b0;
    while (!acc && waits < 50) begin
      @(negedge clk);
      acc = o_ready;
      if (!acc) begin
        waits++;
        @(posedge clk); #1;
      end
    end
    if (!acc) check_eq("accept_timeout", o_ready, 1'b1);
  endtask

  task automatic go_idle();
    @(posedge clk); #1;
    i_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    check_eq("sb_empty", sb_q.size(), 0);
  endtask

  initial begin
    int base, n;
    i_rst = 1'b1; i_valid = 1'b0; i_ready = 1'b1;
    i_data = '0; i_ctrl = '0; i_shift_amount = '0; i_tag = '0;
    repeat (3) @(posedge clk);
    #1 i_rst = 1'b0;
    @(negedge clk);
    check_eq("rst_valid", o_valid, 1'b0);
    check_eq("rst_data", o_data, 8'h00);
    check_eq("rst_carry", o_carry, 1'b0);
    check_eq("rst_tag", o_tag, 4'h0);
    check_eq("rst_ready", o_ready, 1'b1);

    directed(3'b001, 8'hB4, 4'd3, 4'd1);
    directed(3'b010, 8'h80, 4'd12, 4'd2);
    directed(3'b100, 8'h01, 4'd8, 4'd3);
    directed(3'b100, 8'h01, 4'd9, 4'd4);
    directed(3'b011, 8'h81, 4'd9, 4'd5);
    directed(3'b110, 8'h81, 4'd1, 4'd6);
    directed(3'b101, 8'h5A, 4'd3, 4'd7);
    directed(3'b000, 8'hC3, 4'd5, 4'd8);
    directed(3'b001, 8'hA5, 4'd0, 4'd9);
    directed(3'b001, 8'h80, 4'd8, 4'd10);
    directed(3'b010, 8'h6C, 4'd4, 4'd11);
    directed(3'b010, 8'h40, 4'd9, 4'd12);
    drain();

    // Stream of 6 with a 5-cycle downstream stall after the first result.
    base = n_out;
    saw_busy = 1'b0;
    fork
      begin
        for (int t = 0; t < 6; t++) push_req(3'b100, 8'h11 * (t + 1), 4'(t), 4'(t));
        go_idle();
      end
      begin
        n = 0;
        do begin
          @(negedge clk);
          n++;
        end while (!o_valid && n < 20);
        @(posedge clk); #1;
        i_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1 i_ready = 1'b1;
      end
    join
    drain();
    check_eq("stream_count", n_out - base, 6);
    check_eq("ready_dropped", saw_busy, 1'b1);

    // Reset with two requests in flight.
    push_req(3'b001, 8'hF0, 4'd1, 4'd13);
    push_req(3'b110, 8'h0F, 4'd2, 4'd14);
    @(posedge clk); #1;
    i_valid = 1'b0;
    i_rst = 1'b1;
    @(posedge clk); #1;
    i_rst = 1'b0;
    sb_q.delete();
    @(negedge clk);
    check_eq("midrst_valid", o_valid, 1'b0);
    check_eq("midrst_data", o_data, 8'h00);
    check_eq("midrst_ready", o_ready, 1'b1);
    repeat (6) begin
      @(negedge clk);
      check_eq("post_rst_valid", o_valid, 1'b0);
    end

    // Random traffic with random back-pressure.
    base = n_out;
    rnd_done = 1'b0;
    fork
      begin
        for (int t = 0; t < 40; t++)
          push_req(3'($urandom_range(0, 7)), 8'($urandom), 4'($urandom_range(0, 15)), 4'(t));
        go_idle();
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk); #1;
          i_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    i_ready = 1'b1;
    drain();
    check_eq("random_count", n_out - base, 40);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
